// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state, forward-select and timeout constants for hazard_ctrl
package hazard_pkg;

    // Controller states (plain constants so older tools and dumps see raw codes)
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_MDU_WAIT = 2'd2;

    // Operand forward-select encodings
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Default number of wait cycles before a stuck wait is forcibly released
    localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - per-operand forwarding source select, M stage beats W stage
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrite_m_i,
    input  logic       regwrite_w_i,
    output logic [1:0] fwd_sel_o
);

    // Youngest producer wins; x0 is never forwarded since it is hardwired zero
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (regwrite_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_sel_o = FWD_M;
        end else if (regwrite_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, stalls, flushes, wait timeout
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        regwrite_m,
    input  logic        regwrite_w,
    input  logic        load_e,
    input  logic        pcsrc_e,
    input  logic        mem_req_m,
    input  logic        mem_ready_m,
    input  logic        mdu_start_e,
    input  logic        mdu_done,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        fd_clr,
    output logic        de_clr,
    output logic        em_clr,
    output logic        mw_clr,
    output logic [1:0]  fwd_a_e,
    output logic [1:0]  fwd_b_e,
    output logic        err_timeout,
    output logic [31:0] stall_cycles
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   stall_q, stall_d;

    logic mem_stall;
    logic load_use;
    logic tmo;
    logic run_active;
    logic mask_mem;
    logic mask_mdu;

    fwd_unit u_fwd_a (
        .rs_i         (rs1_e),
        .rd_m_i       (rd_m),
        .rd_w_i       (rd_w),
        .regwrite_m_i (regwrite_m),
        .regwrite_w_i (regwrite_w),
        .fwd_sel_o    (fwd_a_e)
    );

    fwd_unit u_fwd_b (
        .rs_i         (rs2_e),
        .rd_m_i       (rd_m),
        .rd_w_i       (rd_w),
        .regwrite_m_i (regwrite_m),
        .regwrite_w_i (regwrite_w),
        .fwd_sel_o    (fwd_b_e)
    );

    assign mem_stall = mem_req_m && !mem_ready_m;
    assign load_use  = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign tmo       = (cnt_q == CNT_LAST);

    // Stage control and next state; a release cycle reuses the RUN rules but
    // masks the condition that caused the wait so it cannot immediately re-arm
    always_comb begin
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        de_en      = 1'b1;
        em_en      = 1'b1;
        fd_clr     = 1'b0;
        de_clr     = 1'b0;
        em_clr     = 1'b0;
        mw_clr     = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        run_active = 1'b0;
        mask_mem   = 1'b0;
        mask_mdu   = 1'b0;

        case (state_q)
            ST_MEM_WAIT: begin
                if (mem_ready_m || tmo) begin
                    run_active = 1'b1;
                    mask_mem   = 1'b1;
                    if (!mem_ready_m) begin
                        err_d = 1'b1;
                    end
                end else begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    de_en  = 1'b0;
                    em_en  = 1'b0;
                    mw_clr = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done || tmo) begin
                    run_active = 1'b1;
                    mask_mdu   = 1'b1;
                    if (!mdu_done) begin
                        err_d = 1'b1;
                    end
                end else begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    de_en  = 1'b0;
                    em_clr = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: begin
                run_active = 1'b1;
            end
        endcase

        if (run_active) begin
            state_d = ST_RUN;
            if (mem_stall && !mask_mem) begin
                pc_en   = 1'b0;
                fd_en   = 1'b0;
                de_en   = 1'b0;
                em_en   = 1'b0;
                mw_clr  = 1'b1;
                state_d = ST_MEM_WAIT;
                cnt_d   = '0;
            end else if (mdu_start_e && !mask_mdu) begin
                pc_en   = 1'b0;
                fd_en   = 1'b0;
                de_en   = 1'b0;
                em_clr  = 1'b1;
                state_d = ST_MDU_WAIT;
                cnt_d   = '0;
            end else if (pcsrc_e) begin
                fd_clr = 1'b1;
                de_clr = 1'b1;
            end else if (load_use) begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                de_clr = 1'b1;
            end
        end
    end

    // Saturating stall-cycle counter, advancing whenever fetch is held
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // State, wait counter, sticky timeout flag and stall count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign err_timeout  = err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
    logic [4:0]  rd_e = '0, rd_m = '0, rd_w = '0;
    logic        regwrite_m = 1'b0, regwrite_w = 1'b0, load_e = 1'b0, pcsrc_e = 1'b0;
    logic        mem_req_m = 1'b0, mem_ready_m = 1'b0, mdu_start_e = 1'b0, mdu_done = 1'b0;
    logic        pc_en, fd_en, de_en, em_en, fd_clr, de_clr, em_clr, mw_clr;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        err_timeout;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // {pc_en, fd_en, de_en, em_en, fd_clr, de_clr, em_clr, mw_clr}
    localparam logic [7:0] C_DEF = 8'b1111_0000;
    localparam logic [7:0] C_LU  = 8'b0011_0100;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_MEM = 8'b0000_0001;
    localparam logic [7:0] C_MDU = 8'b0001_0010;

    wire [7:0] ctl = {pc_en, fd_en, de_en, em_en, fd_clr, de_clr, em_clr, mw_clr};

    hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .regwrite_m   (regwrite_m),
        .regwrite_w   (regwrite_w),
        .load_e       (load_e),
        .pcsrc_e      (pcsrc_e),
        .mem_req_m    (mem_req_m),
        .mem_ready_m  (mem_ready_m),
        .mdu_start_e  (mdu_start_e),
        .mdu_done     (mdu_done),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_en        (de_en),
        .em_en        (em_en),
        .fd_clr       (fd_clr),
        .de_clr       (de_clr),
        .em_clr       (em_clr),
        .mw_clr       (mw_clr),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e),
        .err_timeout  (err_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // asynchronous reset, no clock edge yet
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_DEF));
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // forwarding
        rs1_e = 5'd5; rs2_e = 5'd3;
        rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1;
        #1;
        chk("fwd_a_m_over_w", 32'(fwd_a_e), 32'd2);
        chk("fwd_b_none", 32'(fwd_b_e), 32'd0);
        rd_m = 5'd0;
        #1;
        chk("fwd_a_w", 32'(fwd_a_e), 32'd1);
        rs2_e = 5'd5; regwrite_w = 1'b0; rd_m = 5'd5;
        #1;
        chk("fwd_b_m", 32'(fwd_b_e), 32'd2);
        regwrite_m = 1'b0; regwrite_w = 1'b1;
        #1;
        chk("fwd_b_w", 32'(fwd_b_e), 32'd1);
        rs1_e = 5'd0; rd_w = 5'd0;
        #1;
        chk("fwd_a_x0", 32'(fwd_a_e), 32'd0);
        regwrite_w = 1'b0; rd_m = 5'd0; rs2_e = 5'd0;

        // load-use: one bubble
        tick();
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        load_e = 1'b0;
        #1;
        chk("lu_after", 32'(ctl), 32'(C_DEF));
        chk("lu_stall", stall_cycles, 32'd1);
        load_e = 1'b1; rd_e = 5'd0; rs2_d = 5'd0;
        #1;
        chk("lu_x0", 32'(ctl), 32'(C_DEF));
        load_e = 1'b0;

        // taken branch, and branch over load-use
        pcsrc_e = 1'b1;
        #1;
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        tick();
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
        tick();
        chk("br_stall", stall_cycles, 32'd1);
        pcsrc_e = 1'b0; load_e = 1'b0; rd_e = 5'd0; rs2_d = 5'd0;

        // memory wait: 3 frozen cycles then release
        mem_req_m = 1'b1; mem_ready_m = 1'b0;
        #1;
        chk("mem_f0", 32'(ctl), 32'(C_MEM));
        tick();
        chk("mem_f1", 32'(ctl), 32'(C_MEM));
        tick();
        chk("mem_f2", 32'(ctl), 32'(C_MEM));
        tick();
        mem_ready_m = 1'b1;
        #1;
        chk("mem_rel", 32'(ctl), 32'(C_DEF));
        tick();
        mem_req_m = 1'b0; mem_ready_m = 1'b0;
        chk("mem_stall", stall_cycles, 32'd4);
        mdu_done = 1'b1;
        #1;
        chk("mdu_done_run", 32'(ctl), 32'(C_DEF));
        mdu_done = 1'b0;

        // memory stall beats branch and MDU; held branch flushes on release
        mem_req_m = 1'b1; pcsrc_e = 1'b1; mdu_start_e = 1'b1;
        #1;
        chk("memp_f0", 32'(ctl), 32'(C_MEM));
        mdu_start_e = 1'b0;
        tick();
        chk("memp_f1", 32'(ctl), 32'(C_MEM));
        tick();
        mem_ready_m = 1'b1;
        #1;
        chk("memp_rel", 32'(ctl), 32'(C_BR));
        tick();
        mem_req_m = 1'b0; mem_ready_m = 1'b0; pcsrc_e = 1'b0;
        chk("memp_stall", stall_cycles, 32'd6);

        // MDU wait with completion
        mdu_start_e = 1'b1;
        #1;
        chk("mdu_f0", 32'(ctl), 32'(C_MDU));
        tick();
        chk("mdu_f1", 32'(ctl), 32'(C_MDU));
        tick();
        mdu_done = 1'b1;
        #1;
        chk("mdu_rel", 32'(ctl), 32'(C_DEF));
        tick();
        mdu_done = 1'b0; mdu_start_e = 1'b0;
        #1;
        chk("mdu_after", 32'(ctl), 32'(C_DEF));
        chk("mdu_stall", stall_cycles, 32'd8);

        // MDU timeout after 4 frozen cycles
        mdu_start_e = 1'b1;
        #1;
        chk("tmo_f0", 32'(ctl), 32'(C_MDU));
        tick();
        chk("tmo_f1", 32'(ctl), 32'(C_MDU));
        tick();
        chk("tmo_f2", 32'(ctl), 32'(C_MDU));
        tick();
        chk("tmo_f3", 32'(ctl), 32'(C_MDU));
        chk("tmo_err_early", 32'(err_timeout), 32'd0);
        tick();
        chk("tmo_rel", 32'(ctl), 32'(C_DEF));
        mdu_start_e = 1'b0;
        tick();
        chk("tmo_err", 32'(err_timeout), 32'd1);
        chk("tmo_run", 32'(ctl), 32'(C_DEF));
        chk("tmo_stall", stall_cycles, 32'd12);
        tick();
        tick();
        chk("tmo_sticky", 32'(err_timeout), 32'd1);

        // reset in the middle of a memory wait
        mem_req_m = 1'b1;
        tick();
        tick();
        chk("rstw_frozen", 32'(ctl), 32'(C_MEM));
        rst_n = 1'b0;
        #1;
        chk("rstw_err", 32'(err_timeout), 32'd0);
        chk("rstw_stall", stall_cycles, 32'd0);
        mem_req_m = 1'b0;
        #1;
        chk("rstw_ctl", 32'(ctl), 32'(C_DEF));
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstw_run", 32'(ctl), 32'(C_DEF));
        chk("rstw_stall_after", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
